qpsk_modulator: RTL and testbench
=================================

Name: qpsk_modulator

Overview:
Digital QPSK modulator with a serial bit input and a 1-bit square-wave carrier output.
- Samples the serial bit stream `x` at a fixed bit rate and groups the bits into dibits.
- Each dibit selects one of four carrier phases (0°, 90°, 180°, 270°).
- The carrier is derived from the system clock.
- Sits between the serial data source and the DAC or line driver of the transmit chain.

Parameters:
- BIT_CLKS, 4, clock cycles per input bit. Integer ≥2. 2*BIT_CLKS must be a multiple of 4*CARRIER_QTR.
- CARRIER_QTR, 1, clock cycles per carrier quarter-period. Carrier period = 4*CARRIER_QTR clocks.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- x    input  1  serial data bit, held by the source for BIT_CLKS cycles per bit.
- y    output 1  registered QPSK square-wave carrier.

Behaviour:
- Reset (rst=1, asynchronous): clears all state immediately.
  - bit_cnt=0, ph=0, half=0, first=0, sym=00, y=0.
  - While rst=1, `x` is ignored and y stays 0.
- bit_cnt: counts 0..BIT_CLKS-1 and wraps.
- Bit sampling: `x` is sampled only on the edge where bit_cnt==BIT_CLKS-1. Values of `x` between sample edges are irrelevant.
- Dibit assembly:
  - At a sample edge with half=0: first<=x, half<=1.
  - At a sample edge with half=1: sym<={first,x}, half<=0.
  - The first-received bit is the MSB.
- Carrier phase counter `ph`: free-running 0..4*CARRIER_QTR-1, increments every clock, wraps to 0.
- Phase index k selected by sym (Gray mapping):
  - 00→k=0 (0°)
  - 01→k=1 (90°)
  - 11→k=2 (180°)
  - 10→k=3 (270°)
- Output carrier:
  - Shifted counter p = (ph - k*CARRIER_QTR) mod 4*CARRIER_QTR.
  - carrier = 1 when p < 2*CARRIER_QTR, else 0.
- Output register: each edge, y <= carrier computed from the pre-edge values of ph and sym. Latency is 1 clock.
- Symbol change: a new sym value first affects y on the edge after sym is loaded.
  - Counting edges n=1,2,... after reset release, the first symbol loads at edge 2*BIT_CLKS.
  - Its phase appears on y from edge 2*BIT_CLKS+1.
- Alignment: bit_cnt and ph both start at 0, so with default parameters symbol boundaries coincide with ph wrap (ph=0 at edge 2*BIT_CLKS+1).
- Reset mid-operation: all state returns to reset values immediately. After release, sequencing restarts from edge 1 as if freshly reset; a partially assembled dibit is discarded.
- No handshake: the source must keep to the BIT_CLKS bit timing.

Test Plan:
(Default parameters; edges numbered from reset release.)
1. Reset check: hold rst=1 for 3 clocks while toggling x → y=0 throughout, and y drops to 0 asynchronously on rst assertion.
2. x=0 constant → y sequence from edge 1 is 1,1,0,0 repeating indefinitely (sym=00, 0°).
3. x=1 constant → edges 1–8: 1,1,0,0,1,1,0,0; from edge 9 (sym=11, 180°): 0,0,1,1 repeating.
4. Dibit 01 (x=0 sampled at edge 4, x=1 at edge 8) → from edge 9: 0,1,1,0 repeating (90°). Dibit 10 → from edge 9: 1,0,0,1 repeating (270°).
5. Glitches on x: toggle x between sample edges while the values at edges 4 and 8 are 1,0 → sym=10; intermediate toggles have no effect on y.
6. Async reset mid-symbol: assert rst between edges 5 and 6, hold 2 clocks, release, then drive x=1 constant → y=0 during reset; pattern restarts at 1,1,0,0 from the new edge 1; 180° pattern from new edge 9.

Source files
------------

// File: rtl/qpsk_modulator_if.sv
// Serial-bit / carrier-out port bundle for the QPSK modulator.
// The master drives the data bit; the slave (modulator) drives the carrier.
interface qpsk_modulator_if;
    logic x;
    logic y;

    modport master (output x, input y);
    modport slave  (input x, output y);
endinterface

// File: rtl/qpsk_modulator.sv
// QPSK modulator: samples a serial bit stream, pairs bits into Gray-coded dibits,
// and emits a 1-bit square-wave carrier whose phase follows the current dibit.
module qpsk_modulator #(
    parameter int BIT_CLKS    = 4,
    parameter int CARRIER_QTR = 1
) (
    input  logic             clk,
    input  logic             rst,
    qpsk_modulator_if.slave  s_if
);

    localparam int PER  = 4 * CARRIER_QTR;
    localparam int PH_W = $clog2(PER);
    localparam int BC_W = $clog2(BIT_CLKS);

    logic [BC_W-1:0] r_bit_cnt;
    logic [PH_W-1:0] r_ph;
    logic            r_half;
    logic            r_first;
    logic [1:0]      r_sym;
    logic            r_y;

    logic            w_sample;
    logic [PH_W-1:0] w_off;
    logic [PH_W-1:0] w_p;
    logic            w_carrier;

    assign w_sample = (r_bit_cnt == BC_W'(BIT_CLKS - 1));

    // Gray mapping: 00->0, 01->90, 11->180, 10->270 degrees, as a phase-counter offset.
    always_comb begin
        w_off = '0;
        case (r_sym)
            2'b00:   w_off = '0;
            2'b01:   w_off = PH_W'(CARRIER_QTR);
            2'b11:   w_off = PH_W'(2 * CARRIER_QTR);
            2'b10:   w_off = PH_W'(3 * CARRIER_QTR);
            default: w_off = '0;
        endcase
    end

    // Modular subtraction; when PER is a power of two the truncated PER is zero
    // and the natural wrap of the PH_W-bit result gives the same answer.
    assign w_p       = (r_ph >= w_off) ? (r_ph - w_off) : (r_ph + PH_W'(PER) - w_off);
    assign w_carrier = (w_p < PH_W'(2 * CARRIER_QTR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_ph      <= '0;
            r_half    <= 1'b0;
            r_first   <= 1'b0;
            r_sym     <= 2'b00;
            r_y       <= 1'b0;
        end else begin
            r_bit_cnt <= w_sample ? '0 : r_bit_cnt + 1'b1;
            r_ph      <= (r_ph == PH_W'(PER - 1)) ? '0 : r_ph + 1'b1;
            r_y       <= w_carrier;
            if (w_sample) begin
                if (!r_half) begin
                    r_first <= s_if.x;
                    r_half  <= 1'b1;
                end else begin
                    r_sym   <= {r_first, s_if.x};
                    r_half  <= 1'b0;
                end
            end
        end
    end

    assign s_if.y = r_y;

endmodule

// File: tb/tb_qpsk_modulator.sv
// Self-checking bench for qpsk_modulator: fixed dibit table, hand-written reset
// sequences, and random bit streams compared against an arithmetic reference.
module tb_qpsk_modulator;

    localparam int BIT_CLKS    = 4;
    localparam int CARRIER_QTR = 1;
    localparam int PER         = 4 * CARRIER_QTR;

    logic clk = 1'b0;
    logic rst = 1'b1;

    qpsk_modulator_if bus ();

    qpsk_modulator #(
        .BIT_CLKS    (BIT_CLKS),
        .CARRIER_QTR (CARRIER_QTR)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dib;
        logic [3:0] exp_y;
    } vec_t;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    logic stim_bits [64];

    task automatic check(input string name, input int n, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s edge %0d: y=%b expected %b", name, n, act, exp);
    endtask

    // Expected y at edge n: phase of the last completed dibit applied to the
    // free-running carrier position seen before that edge.
    function automatic logic model_y(input int n);
        int d;
        int k;
        int pos;
        logic [1:0] s;
        d = (n - 1) / (2 * BIT_CLKS);
        k = 0;
        if (d > 0) begin
            s = {stim_bits[2*(d-1)], stim_bits[2*(d-1)+1]};
            case (s)
                2'b00: k = 0;
                2'b01: k = 1;
                2'b11: k = 2;
                default: k = 3;
            endcase
        end
        pos = (((n - 1) % PER) - k * CARRIER_QTR + PER) % PER;
        return (pos < 2 * CARRIER_QTR);
    endfunction

    // Assert reset now, optionally check the asynchronous drop, hold, and
    // release on a falling edge so the next rising edge is edge 1.
    task automatic do_reset(input bit chk_async, input int hold);
        rst = 1'b1;
        if (chk_async) begin
            #1 check("async_drop", 0, bus.y, 1'b0);
        end
        repeat (hold) begin
            @(negedge clk);
            bus.x = 1'($urandom);
            @(posedge clk);
            #1 check("reset_hold", 0, bus.y, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive stim_bits for edges 1..nedges, checking y after each edge.
    // With glitch set, x is randomised on every non-sampling edge.
    task automatic run(input int nedges, input bit glitch, input string name);
        for (int n = 1; n <= nedges; n++) begin
            if (glitch && (n % BIT_CLKS) != 0) bus.x = 1'($urandom);
            else                                bus.x = stim_bits[(n - 1) / BIT_CLKS];
            @(posedge clk);
            #1 check(name, n, bus.y, model_y(n));
            @(negedge clk);
        end
    endtask

    task automatic fill_const(input logic v);
        for (int i = 0; i < 64; i++) stim_bits[i] = v;
    endtask

    initial begin
        vec_t vecs [4];
        vecs[0] = '{dib: 2'b00, exp_y: 4'b1100};
        vecs[1] = '{dib: 2'b01, exp_y: 4'b0110};
        vecs[2] = '{dib: 2'b11, exp_y: 4'b0011};
        vecs[3] = '{dib: 2'b10, exp_y: 4'b1001};

        bus.x = 1'b0;
        do_reset(1'b0, 3);

        // Table: one dibit, then four carrier edges with known phase.
        for (int g = 0; g < 2; g++) begin
            for (int v = 0; v < 4; v++) begin
                fill_const(1'b0);
                stim_bits[0] = vecs[v].dib[1];
                stim_bits[1] = vecs[v].dib[0];
                run(2 * BIT_CLKS, g[0], "vec_lead");
                for (int i = 0; i < 4; i++) begin
                    bus.x = 1'($urandom);
                    @(posedge clk);
                    #1 check(g ? "vec_glitch" : "vec_table", 2 * BIT_CLKS + 1 + i,
                             bus.y, vecs[v].exp_y[3-i]);
                    @(negedge clk);
                end
                do_reset(1'b1, 2);
            end
        end

        fill_const(1'b0);
        run(32, 1'b0, "const0");
        do_reset(1'b1, 3);

        fill_const(1'b1);
        run(32, 1'b0, "const1");
        do_reset(1'b1, 3);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) stim_bits[i] = 1'($urandom);
            run(20 * BIT_CLKS, r[0], "random");
            do_reset(1'b1, 2);
        end

        // Reset between edges 5 and 6 discards the half-built dibit.
        for (int i = 0; i < 64; i++) stim_bits[i] = 1'($urandom);
        stim_bits[0] = 1'b1;
        run(5, 1'b0, "pre_midrst");
        do_reset(1'b1, 2);
        fill_const(1'b1);
        run(16, 1'b0, "post_midrst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
